// File: rtl/note_phase_gen.sv
// Per-voice phase stepper: walks the 48-entry wave-table index at 48x the note
// frequency and, after key release, parks at the next zero crossing of the wave.
module note_phase_gen #(
  parameter int DIV_W = 14
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       key_down,
  input  logic [3:0] note,
  input  logic [1:0] octave,
  output logic [5:0] select,
  output logic       active,
  output logic       step
);

  // state   | meaning
  // IDLE    | silent, select parked at 0
  // RUN     | key held, stepping select every div cycles
  // RELEASE | key up, stepping until select reaches a zero crossing (0 or 24)
  typedef enum logic [1:0] {IDLE, RUN, RELEASE} state_t;

  state_t           state_q, state_d;
  logic [DIV_W-1:0] cnt_q, cnt_d, div_q, div_d, new_div, cnt_adv;
  logic [3:0]       note_q, note_d;
  logic [1:0]       oct_q, oct_d;
  logic [5:0]       select_q, select_d, sel_inc, sel_adv;
  logic             active_q, active_d, step_q, step_d;
  logic             pair_valid, pair_changed, tc;

  // Octave-4 dividers for 50 MHz; other octaves derive by shifting.
  function automatic logic [DIV_W-1:0] lookup_div(input logic [3:0] n, input logic [1:0] o);
    logic [DIV_W-1:0] base;
    case (n)
      4'd0:    base = DIV_W'(3982);
      4'd1:    base = DIV_W'(3758);
      4'd2:    base = DIV_W'(3547);
      4'd3:    base = DIV_W'(3348);
      4'd4:    base = DIV_W'(3160);
      4'd5:    base = DIV_W'(2983);
      4'd6:    base = DIV_W'(2815);
      4'd7:    base = DIV_W'(2657);
      4'd8:    base = DIV_W'(2508);
      4'd9:    base = DIV_W'(2367);
      4'd10:   base = DIV_W'(2235);
      4'd11:   base = DIV_W'(2109);
      default: base = '0;
    endcase
    return (base << 1) >> o;
  endfunction

  assign pair_valid   = note < 4'd12;
  assign pair_changed = (note != note_q) || (octave != oct_q);
  assign new_div      = lookup_div(note, octave);
  assign tc           = cnt_q == div_q - DIV_W'(1);
  assign sel_inc      = (select_q == 6'd47) ? 6'd0 : select_q + 6'd1;
  assign cnt_adv      = tc ? '0 : cnt_q + DIV_W'(1);
  assign sel_adv      = tc ? sel_inc : select_q;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    div_d    = div_q;
    note_d   = note_q;
    oct_d    = oct_q;
    select_d = select_q;
    active_d = active_q;
    step_d   = 1'b0;
    case (state_q)
      IDLE: begin
        select_d = '0;
        cnt_d    = '0;
        active_d = 1'b0;
        if (key_down && pair_valid) begin
          note_d  = note;
          oct_d   = octave;
          div_d   = new_div;
          state_d = RUN;
        end
      end
      RUN: begin
        // First RUN cycle after IDLE only raises active; counting starts here.
        if (!active_q) begin
          active_d = 1'b1;
          cnt_d    = '0;
        end else if (key_down && pair_valid && pair_changed) begin
          note_d = note;
          oct_d  = octave;
          div_d  = new_div;
          cnt_d  = '0;
        end else begin
          cnt_d    = cnt_adv;
          select_d = sel_adv;
          step_d   = tc;
          if (!key_down) state_d = RELEASE;
        end
      end
      RELEASE: begin
        if (key_down && pair_valid) begin
          state_d = RUN;
          if (pair_changed) begin
            note_d = note;
            oct_d  = octave;
            div_d  = new_div;
            cnt_d  = '0;
          end else begin
            cnt_d    = cnt_adv;
            select_d = sel_adv;
            step_d   = tc;
          end
        end else if (select_q == 6'd0 || select_q == 6'd24) begin
          state_d  = IDLE;
          select_d = '0;
          cnt_d    = '0;
          active_d = 1'b0;
        end else begin
          cnt_d    = cnt_adv;
          select_d = sel_adv;
          step_d   = tc;
          if (tc && (sel_inc == 6'd0 || sel_inc == 6'd24)) begin
            select_d = '0;
            active_d = 1'b0;
            state_d  = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      div_q    <= '0;
      note_q   <= '0;
      oct_q    <= '0;
      select_q <= '0;
      active_q <= 1'b0;
      step_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      div_q    <= div_d;
      note_q   <= note_d;
      oct_q    <= oct_d;
      select_q <= select_d;
      active_q <= active_d;
      step_q   <= step_d;
    end
  end

  assign select = select_q;
  assign active = active_q;
  assign step   = step_q;

endmodule

// File: tb/tb_note_phase_gen.sv
// Bench for note_phase_gen: directed sequence with randomized notes and timing,
// checked against divider arithmetic and zero-crossing rules.
module tb_note_phase_gen;

  logic       clk = 1'b0;
  logic       reset, key_down;
  logic [3:0] note;
  logic [1:0] octave;
  logic [5:0] select;
  logic       active, step;

  int          vectors = 0;
  int          miscompares = 0;
  int          sel_m, cur_div;
  int unsigned cyc_cnt = 0;
  int          base_tab [12] = '{3982, 3758, 3547, 3348, 3160, 2983,
                                 2815, 2657, 2508, 2367, 2235, 2109};

  note_phase_gen #(.DIV_W(14)) dut (
    .clk(clk), .reset(reset), .key_down(key_down), .note(note), .octave(octave),
    .select(select), .active(active), .step(step)
  );

  always #5 clk = ~clk;

  function automatic int div_of(input int n, input int o);
    return (base_tab[n] * 2) / (1 << o);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
    cyc_cnt++;
  endtask

  task automatic next_step(input int max_cyc, output int n);
    n = 0;
    do begin
      cyc();
      n++;
    end while (step !== 1'b1 && n < max_cyc);
  endtask

  task automatic step_one();
    int n;
    next_step(cur_div + 4, n);
    chk("step_spacing", n, cur_div);
    sel_m = (sel_m + 1) % 48;
    chk("step_select", select, sel_m);
  endtask

  task automatic press(input int n, input int o);
    note = 4'(n);
    octave = 2'(o);
    key_down = 1'b1;
    cyc();
    chk("press_active_k", active, 0);
    cyc();
    chk("press_active_k1", active, 1);
    chk("press_select", select, 0);
    sel_m = 0;
    cur_div = div_of(n, o);
  endtask

  // Key up: stepping continues to the next multiple of 24, which reads as 0.
  task automatic release_to_zero();
    int k, n, exp_s;
    key_down = 1'b0;
    k = 24 - (sel_m % 24);
    for (int i = 0; i < k; i++) begin
      next_step(cur_div + 4, n);
      chk("rel_spacing", n, cur_div);
      exp_s = (sel_m + 1) % 48;
      if (exp_s % 24 == 0) exp_s = 0;
      chk("rel_select", select, exp_s);
      chk("rel_active", active, (i == k - 1) ? 0 : 1);
      sel_m = exp_s;
    end
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_select"}, select, 0);
    chk({tag, "_active"}, active, 0);
    chk({tag, "_step"}, step, 0);
  endtask

  initial begin
    int n, r, t0;
    reset = 1'b1;
    key_down = 1'b0;
    note = '0;
    octave = '0;
    repeat (3) cyc();
    chk_reset_state("rst");
    reset = 1'b0;
    cyc();

    for (int i = 0; i < 4; i++) begin
      note = 4'(12 + i);
      octave = 2'($urandom_range(0, 3));
      key_down = 1'b1;
      repeat (20 + $urandom_range(0, 20)) cyc();
      chk("invalid_active", active, 0);
      chk("invalid_select", select, 0);
    end
    key_down = 1'b0;
    cyc();

    // A4: first step latency, invalid change ignored, then retrigger to C4.
    press(9, 1);
    step_one();
    note = 4'd14;
    step_one();
    note = 4'd0;
    octave = 2'd1;
    cyc();
    chk("retrig_hold_select", select, 2);
    chk("retrig_no_step", step, 0);
    cur_div = div_of(0, 1);
    step_one();
    key_down = 1'b0;
    r = $urandom_range(50, 500);
    repeat (r) cyc();
    chk("release_active", active, 1);
    key_down = 1'b1;
    next_step(cur_div + 4, n);
    chk("repress_spacing", n, cur_div - r);
    sel_m = 4;
    chk("repress_select", select, sel_m);
    chk("repress_active", active, 1);
    key_down = 1'b0;
    repeat ($urandom_range(20, 400)) cyc();
    chk("mid_release_active", active, 1);
    reset = 1'b1;
    cyc();
    chk_reset_state("rst_release");
    reset = 1'b0;
    repeat (30) cyc();
    chk("after_rst_active", active, 0);
    chk("after_rst_select", select, 0);

    // C3: longest divider.
    press(0, 0);
    step_one();
    reset = 1'b1;
    key_down = 1'b0;
    cyc();
    reset = 1'b0;
    cyc();
    chk("c3_rst_active", active, 0);

    // Release at select 10 with a random high-octave note.
    press(10 + $urandom_range(0, 1), 3);
    repeat (10) step_one();
    release_to_zero();
    next_step(cur_div + 4, n);
    chk("idle_no_step", step, 0);
    chk("idle_select", select, 0);
    chk("idle_active", active, 0);

    // A6: run to 30, release; whole excursion spans one full wave period.
    press(9, 3);
    t0 = cyc_cnt;
    repeat (30) step_one();
    release_to_zero();
    chk("wave_period", cyc_cnt - t0, 48 * cur_div);

    // B6: reset mid-RUN at select 40, restart only on key press.
    press(11, 3);
    repeat (40) step_one();
    reset = 1'b1;
    key_down = 1'b0;
    cyc();
    chk_reset_state("rst_run");
    reset = 1'b0;
    repeat (20) cyc();
    chk("no_restart_active", active, 0);
    chk("no_restart_select", select, 0);
    press(11, 3);
    key_down = 1'b0;
    cyc();
    chk("zentry_hold_active", active, 1);
    cyc();
    chk_reset_state("zentry");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/note_phase_gen.md
# note_phase_gen

Per-voice phase stepper for the piano: turns a held key (note code plus octave) into the 6-bit `select` index that drives the 48-entry triangle wave table. It advances `select` through 0..47 at 48× the note frequency. On key release it stops cleanly at the next zero crossing of the wave, so the output does not click. One instance sits directly upstream of each wave-table instance.

## Interface
- `DIV_W`, 14: width of the step-interval counter and divider register.
- `clk`  in  1  system clock, 50 MHz; the divider table is computed for this frequency.
- `reset`  in  1  synchronous, active-high reset.
- `key_down`  in  1  level, high while the key is held.
- `note`  in  4  note code: 0 = C, 1 = C#, ..., 11 = B; 12..15 are invalid.
- `octave`  in  2  0 = octave 3, 1 = octave 4, 2 = octave 5, 3 = octave 6.
- `select`  out  6  wave-table index, 0..47.
- `active`  out  1  high while the voice is sounding (RUN or RELEASE).
- `step`  out  1  one-cycle pulse on every `select` update caused by a step.

## Operation
- Base dividers for octave 4, indexed by note 0..11: 3982, 3758, 3547, 3348, 3160, 2983, 2815, 2657, 2508, 2367, 2235, 2109. Each is 50e6 / (48·f), rounded to nearest.
- Effective divider: `div = (base << 1) >> octave` (integer, truncating). Examples: A4 = 2367, A3 = 4734, A6 = 591.
- A note/octave pair is valid only when `note < 12`.
- States: IDLE, RUN, RELEASE.
- **IDLE**
  - `select = 0`, counter = 0.
  - If `key_down` = 1 and the pair is valid: latch note/octave, load `div`, clear counter, go to RUN.
  - If the pair is invalid: stay in IDLE.
- **RUN**
  - The counter increments every cycle.
  - When the counter equals `div - 1`: counter ← 0, `select` ← (`select == 47`) ? 0 : `select + 1`, and `step` pulses.
  - If `key_down` = 1 with a valid pair that differs from the latched pair: latch the new pair, load the new `div`, clear the counter, and keep `select` unchanged (phase-continuous retrigger).
  - A changed pair that is invalid is ignored.
  - If `key_down` = 0: go to RELEASE; the counter and `select` continue uninterrupted.
- **RELEASE**
  - Stepping continues exactly as in RUN.
  - A step that would produce `select` 0 or 24 (wave value 0) instead sets `select` ← 0, `active` ← 0, and returns to IDLE; `step` still pulses on that cycle.
  - If `select` is already 0 or 24 on the cycle RELEASE is entered: go to IDLE on the next edge with `select` ← 0, no `step` pulse.
  - If `key_down` = 1 with a valid pair: return to RUN, latching the pair. If the pair changed, clear the counter; keep `select` unchanged.
- Reset at any time, including mid-RUN or mid-RELEASE, takes priority: state IDLE, `select = 0`, `active = 0`, `step = 0`, counter = 0, latched pair = 0.

## Timing
- All outputs are registered. Reset values: `select = 0`, `active = 0`, `step = 0`.
- If `key_down` is sampled high (valid pair) at edge k, `active` is high after edge k+1.
- `select` first reads 1, with `step` high, exactly `div` cycles after `active` rises. Each subsequent step follows `div` cycles later.
- A full wave period is `48·div` cycles.
- `step` is high for exactly one cycle per step and is coincident with the new `select` value.
- A release takes effect on the edge after `key_down` is sampled low.
- `active` falls on the same edge that forces `select` to 0.
- A retrigger restarts the interval: the next step occurs `div_new` cycles after the latch.
- At most one `select` change per cycle.
- The counter never exceeds `div - 1`; there is no overflow for any divider up to 7964 (fits in 13 bits).

## Test plan
- Reset, then `key_down` = 1 with note 9, octave 1: `active` rises 1 cycle later; `select` = 1 after 2367 cycles; `select` returns to 0 after 113616 cycles from `active` rising.
- Note 9, octave 3: step interval is 591 cycles. Note 0, octave 0: step interval is 7964 cycles. Check `step` pulse spacing matches each.
- Hold A4, release when `select` = 10: stepping continues 11..23, then `select` goes 23 → 0, `active` falls, and there are exactly 14 `step` pulses after release. Release at `select` = 30: ends at `select` 0 after 18 steps.
- `key_down` = 1 with note 13: stays IDLE, `active` = 0, `select` = 0 indefinitely. While running A4, change to note 14: divider stays 2367.
- While running A4 at `select` = 5, change to note 0, octave 1: `select` holds at 5, then steps every 3982 cycles. Re-press during RELEASE: `active` stays high and no forced zero occurs.
- Assert `reset` mid-RUN at `select` = 40 and mid-RELEASE: the next cycle shows `select` = 0, `active` = 0, `step` = 0; after deassert, the voice restarts only on `key_down`.
